// File: rtl/pmem_responder_pkg.sv
// Shared types for the pmem line interface: line geometry, responder states, request payload.
package pmem_responder_pkg;

    localparam int unsigned LC3B_LINE_OFFSET_BITS = 4;
    localparam int unsigned LC3B_WORD_W           = 16;
    localparam int unsigned LC3B_LINE_W           = 128;

    typedef logic [LC3B_WORD_W-1:0] lc3b_word;
    typedef logic [LC3B_LINE_W-1:0] lc3b_data;

    typedef enum logic [1:0] {
        PMEM_IDLE,
        PMEM_BUSY,
        PMEM_RESP,
        PMEM_CLEAR
    } lc3b_pmem_state;

    typedef struct packed {
        logic     write;
        lc3b_data wdata;
    } pmem_req_t;

    // Line number of a byte address; callers truncate to their index width.
    function automatic lc3b_word line_of(input lc3b_word addr);
        return addr >> LC3B_LINE_OFFSET_BITS;
    endfunction

endpackage

// File: rtl/pmem_array.sv
// Single-port line RAM backing the responder; synchronous write, no reset on the storage.
module pmem_array
    import pmem_responder_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [INDEX_BITS-1:0]  index,
    input  logic [LC3B_LINE_W-1:0] wdata,
    output logic [LC3B_LINE_W-1:0] rdata_c
);

    localparam int unsigned LINES = 1 << INDEX_BITS;

    lc3b_data mem [LINES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
    end

    // Read data is captured by the responder's rdata register on the commit edge.
    assign rdata_c = mem[index];

endmodule

// File: rtl/pmem_responder.sv
// Physical-memory responder for the lc3b pmem line interface: fixed-latency line reads/writebacks.
// Define PMEM_CLEAR_EN to zero the backing store after every reset before accepting requests.
module pmem_responder
    import pmem_responder_pkg::*;
#(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LC3B_WORD_W-1:0] pmem_address,
    input  logic                   pmem_read,
    input  logic                   pmem_write,
    input  logic [LC3B_LINE_W-1:0] pmem_wdata,
    output logic [LC3B_LINE_W-1:0] pmem_rdata,
    output logic                   pmem_resp
);

    localparam int unsigned CNT_W     = $clog2(LATENCY + 1);
    localparam int unsigned LINES     = 1 << INDEX_BITS;
    localparam bit          SKIP_BUSY = (LATENCY == 1);

    lc3b_pmem_state        state_q;
    logic [CNT_W-1:0]      cnt_q;
    pmem_req_t             req_q;
    logic [INDEX_BITS-1:0] idx_q;

    logic                  req_c;
    logic                  commit_c;
    logic                  cur_write_c;
    logic [INDEX_BITS-1:0] cur_idx_c;
    lc3b_data              cur_wdata_c;
    logic                  arr_we_c;
    logic [INDEX_BITS-1:0] arr_idx_c;
    lc3b_data              arr_wdata_c;
    lc3b_data              arr_rdata_c;
`ifdef PMEM_CLEAR_EN
    logic [INDEX_BITS-1:0] clr_idx_q;
`endif

    assign req_c = pmem_read | pmem_write;

    // In IDLE the live request drives the array so LATENCY=1 can commit on the accept edge.
    always_comb begin
        cur_write_c = req_q.write;
        cur_idx_c   = idx_q;
        cur_wdata_c = req_q.wdata;
        commit_c    = 1'b0;
        if (state_q == PMEM_IDLE) begin
            cur_write_c = pmem_write;
            cur_idx_c   = INDEX_BITS'(line_of(pmem_address));
            cur_wdata_c = pmem_wdata;
            commit_c    = SKIP_BUSY && req_c;
        end else if (state_q == PMEM_BUSY) begin
            commit_c    = (cnt_q == CNT_W'(LATENCY - 1));
        end
        arr_we_c    = commit_c && cur_write_c;
        arr_idx_c   = cur_idx_c;
        arr_wdata_c = cur_wdata_c;
`ifdef PMEM_CLEAR_EN
        if (state_q == PMEM_CLEAR) begin
            arr_we_c    = 1'b1;
            arr_idx_c   = clr_idx_q;
            arr_wdata_c = '0;
        end
`endif
    end

    pmem_array #(
        .INDEX_BITS (INDEX_BITS)
    ) u_array (
        .clk     (clk),
        .we      (arr_we_c),
        .index   (arr_idx_c),
        .wdata   (arr_wdata_c),
        .rdata_c (arr_rdata_c)
    );

    // Control FSM, latency counter, request latches and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef PMEM_CLEAR_EN
            state_q   <= PMEM_CLEAR;
            clr_idx_q <= '0;
`else
            state_q   <= PMEM_IDLE;
`endif
            cnt_q      <= '0;
            req_q      <= '0;
            idx_q      <= '0;
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
        end else begin
            pmem_resp <= commit_c;
            if (commit_c && !cur_write_c) begin
                pmem_rdata <= arr_rdata_c;
            end
            case (state_q)
                PMEM_IDLE: begin
                    if (req_c) begin
                        req_q   <= '{write: pmem_write, wdata: pmem_wdata};
                        idx_q   <= cur_idx_c;
                        cnt_q   <= CNT_W'(1);
                        state_q <= SKIP_BUSY ? PMEM_RESP : PMEM_BUSY;
                    end
                end
                PMEM_BUSY: begin
                    if (commit_c) begin
                        state_q <= PMEM_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                PMEM_RESP: begin
                    cnt_q   <= '0;
                    state_q <= PMEM_IDLE;
                end
`ifdef PMEM_CLEAR_EN
                PMEM_CLEAR: begin
                    clr_idx_q <= clr_idx_q + INDEX_BITS'(1);
                    if (clr_idx_q == INDEX_BITS'(LINES - 1)) begin
                        state_q <= PMEM_IDLE;
                    end
                end
`endif
                default: state_q <= PMEM_IDLE;
            endcase
        end
    end

endmodule
